// File: rtl/chan_buf_pkg.sv
// Shared sizing helpers for the multi-channel buffered merge.
// Imported by the RTL and the testbench so all derived widths agree.
package chan_buf_pkg;

   localparam int DEPTH_DEF = 4;
   localparam int OCC_W_DEF = $clog2(DEPTH_DEF) + 1;

   function automatic int calc_chw(input int nch);
      return (nch > 1) ? $clog2(nch) : 1;
   endfunction

   function automatic int calc_cntw(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/chan_buf_fifo.sv
// One channel of buffering: circular storage, wrapping pointers and a separate
// occupancy count that alone decides full/empty.
module chan_buf_fifo
   import chan_buf_pkg::*;
#(
   parameter  int WIDTH_S = 9,
   parameter  int DEPTH   = 4,
   localparam int AW      = $clog2(DEPTH),
   localparam int CNTW    = calc_cntw(DEPTH)
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               flush_i,
   input  logic               push_i,
   input  logic               pop_i,
   input  logic [WIDTH_S-1:0] wdata_i,
   output logic [WIDTH_S-1:0] rdata_o,
   output logic               full_o,
   output logic               empty_o,
   output logic [CNTW-1:0]    count_o
);

   logic [WIDTH_S-1:0] mem_q [DEPTH];
   logic [AW-1:0]      wr_q, wr_d, rd_q, rd_d;
   logic [CNTW-1:0]    cnt_q, cnt_d;
   logic               do_push, do_pop;

   assign full_o  = (cnt_q == CNTW'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign count_o = cnt_q;
   assign rdata_o = mem_q[rd_q];

   // A full FIFO refuses a push even when popped in the same cycle (no bypass).
   assign do_push = push_i && !full_o  && !flush_i;
   assign do_pop  = pop_i  && !empty_o && !flush_i;

   always_comb begin
      wr_d  = wr_q;
      rd_d  = rd_q;
      cnt_d = cnt_q;
      if (flush_i) begin
         wr_d  = '0;
         rd_d  = '0;
         cnt_d = '0;
      end else begin
         if (do_push) wr_d = wr_q + 1'b1;
         if (do_pop)  rd_d = rd_q + 1'b1;
         if (do_push && !do_pop)      cnt_d = cnt_q + 1'b1;
         else if (do_pop && !do_push) cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_q] <= wdata_i;
   end

endmodule

// File: rtl/chan_buf_arb.sv
// N-channel buffered merge: per-channel FIFOs drained round-robin into a single
// registered valid/ready output tagged with the source channel.
module chan_buf_arb
   import chan_buf_pkg::*;
#(
   parameter  int WIDTH_S = 9,
   parameter  int DEPTH   = 4,
   parameter  int NCH     = 2,
   localparam int CHW     = calc_chw(NCH),
   localparam int CNTW    = calc_cntw(DEPTH)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   flush,
   input  logic [NCH-1:0]         in_vld,
   output logic [NCH-1:0]         in_rdy,
   input  logic [NCH*WIDTH_S-1:0] in_data,
   output logic                   out_vld,
   input  logic                   out_rdy,
   output logic [WIDTH_S-1:0]     out_data,
   output logic [CHW-1:0]         out_ch,
   output logic [NCH*CNTW-1:0]    occ
);

   logic                en_q;
   logic [NCH-1:0]      full, empty, pop;
   logic [WIDTH_S-1:0]  rdata [NCH];
   logic [CNTW-1:0]     cnt   [NCH];

   logic                out_vld_q, out_vld_d;
   logic [WIDTH_S-1:0]  out_data_q, out_data_d;
   logic [CHW-1:0]      out_ch_q, out_ch_d;
   logic [CHW-1:0]      rr_q, rr_d;

   logic                gnt_vld, load;
   logic [CHW-1:0]      gnt;

   // Holds in_rdy low until the first edge after reset release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) en_q <= 1'b0;
      else        en_q <= 1'b1;
   end

   for (genvar c = 0; c < NCH; c++) begin : g_ch
      assign in_rdy[c]              = en_q && !full[c] && !flush;
      assign occ[c*CNTW +: CNTW]    = cnt[c];

      chan_buf_fifo #(
         .WIDTH_S (WIDTH_S),
         .DEPTH   (DEPTH)
      ) u_fifo (
         .clk_i   (clk),
         .rst_ni  (rst_n),
         .flush_i (flush),
         .push_i  (in_vld[c] && in_rdy[c]),
         .pop_i   (pop[c]),
         .wdata_i (in_data[c*WIDTH_S +: WIDTH_S]),
         .rdata_o (rdata[c]),
         .full_o  (full[c]),
         .empty_o (empty[c]),
         .count_o (cnt[c])
      );
   end

   always_comb begin
      int idx;
      idx     = 0;
      gnt_vld = 1'b0;
      gnt     = '0;
      for (int i = 0; i < NCH; i++) begin
         idx = (int'(rr_q) + i) % NCH;
         if (!gnt_vld && !empty[idx]) begin
            gnt_vld = 1'b1;
            gnt     = CHW'(idx);
         end
      end
   end

   assign load = (!out_vld_q || out_rdy) && gnt_vld && !flush;

   always_comb begin
      for (int c = 0; c < NCH; c++) pop[c] = load && (gnt == CHW'(c));
   end

   always_comb begin
      out_vld_d  = out_vld_q;
      out_data_d = out_data_q;
      out_ch_d   = out_ch_q;
      rr_d       = rr_q;
      if (flush) begin
         out_vld_d = 1'b0;
         rr_d      = '0;
      end else if (load) begin
         out_vld_d  = 1'b1;
         out_data_d = rdata[gnt];
         out_ch_d   = gnt;
         rr_d       = (int'(gnt) == NCH - 1) ? '0 : gnt + 1'b1;
      end else if (out_rdy) begin
         out_vld_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_vld_q  <= 1'b0;
         out_data_q <= '0;
         out_ch_q   <= '0;
         rr_q       <= '0;
      end else begin
         out_vld_q  <= out_vld_d;
         out_data_q <= out_data_d;
         out_ch_q   <= out_ch_d;
         rr_q       <= rr_d;
      end
   end

   assign out_vld  = out_vld_q;
   assign out_data = out_data_q;
   assign out_ch   = out_ch_q;

endmodule

// File: tb/tb_chan_buf_arb.sv
// Bench for chan_buf_arb: table vectors, directed corner sequences and random
// traffic compared against a queue-based model of the merge.
module tb_chan_buf_arb;
   import chan_buf_pkg::*;

   localparam int W    = 9;
   localparam int D    = 4;
   localparam int N    = 2;
   localparam int CW   = calc_cntw(D);

   logic             clk = 1'b0;
   logic             rst_n, flush, out_vld, out_rdy;
   logic [N-1:0]     in_vld, in_rdy;
   logic [N*W-1:0]   in_data;
   logic [W-1:0]     out_data;
   logic             out_ch;
   logic [N*CW-1:0]  occ;

   chan_buf_arb #(.WIDTH_S(W), .DEPTH(D), .NCH(N)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (flush),
      .in_vld   (in_vld),
      .in_rdy   (in_rdy),
      .in_data  (in_data),
      .out_vld  (out_vld),
      .out_rdy  (out_rdy),
      .out_data (out_data),
      .out_ch   (out_ch),
      .occ      (occ)
   );

   always #5 clk = ~clk;

   int pass_cnt = 0;
   int tot_cnt  = 0;

   // Model: one queue per channel, an output holding slot and a rr pointer.
   logic [W-1:0] mq [N][$];
   bit           m_ovld, m_en;
   logic [W-1:0] m_odata;
   int           m_och, m_rr;

   logic [W-1:0] log_d [$];
   int           log_c [$];
   int           acc_cnt;
   logic [N-1:0] pre_rdy;

   typedef struct {
      logic [1:0] v;
      logic [8:0] d0, d1;
      logic       ordy;
      logic [1:0] exp_rdy;
      logic       exp_ovld;
      logic [8:0] exp_data;
      int         exp_ch;
      int         exp_occ0, exp_occ1;
   } vec_t;

   vec_t tbl [7];

   task automatic chk(input string name, input int act, input int exp);
      tot_cnt++;
      if (act == exp) pass_cnt++;
      else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
   endtask

   function automatic void model_reset();
      for (int c = 0; c < N; c++) mq[c].delete();
      m_ovld  = 1'b0;
      m_odata = '0;
      m_och   = 0;
      m_rr    = 0;
      m_en    = 1'b0;
   endfunction

   function automatic void model_edge(input logic [1:0] v, input logic [W-1:0] d0,
                                      input logic [W-1:0] d1, input logic ordy,
                                      input logic fl);
      bit acc [N];
      bit found;
      int g, idx;
      if (!rst_n) return;
      if (fl) begin
         for (int c = 0; c < N; c++) mq[c].delete();
         m_ovld = 1'b0;
         m_rr   = 0;
      end else begin
         for (int c = 0; c < N; c++) acc[c] = v[c] && m_en && (mq[c].size() < D);
         if (!m_ovld || ordy) begin
            found = 1'b0;
            g     = 0;
            for (int i = 0; i < N; i++) begin
               idx = (m_rr + i) % N;
               if (!found && mq[idx].size() > 0) begin
                  found = 1'b1;
                  g     = idx;
               end
            end
            if (found) begin
               m_odata = mq[g].pop_front();
               m_och   = g;
               m_ovld  = 1'b1;
               m_rr    = (g + 1) % N;
            end else if (ordy) begin
               m_ovld = 1'b0;
            end
         end
         if (acc[0]) mq[0].push_back(d0);
         if (acc[1]) mq[1].push_back(d1);
      end
      m_en = 1'b1;
   endfunction

   task automatic check_outputs();
      chk("out_vld", int'(out_vld), int'(m_ovld));
      if (m_ovld) begin
         chk("out_data", int'(out_data), int'(m_odata));
         chk("out_ch", int'(out_ch), m_och);
      end
      for (int c = 0; c < N; c++)
         chk($sformatf("occ%0d", c), int'(occ[c*CW +: CW]), mq[c].size());
   endtask

   // Starts just after an active edge; ends 1 time unit after the next one.
   task automatic step(input logic [1:0] v, input logic [W-1:0] d0, input logic [W-1:0] d1,
                       input logic ordy, input logic fl);
      bit er;
      in_vld  = v;
      in_data = {d1, d0};
      out_rdy = ordy;
      flush   = fl;
      #1;
      pre_rdy = in_rdy;
      for (int c = 0; c < N; c++) begin
         er = m_en && (mq[c].size() < D) && !fl;
         chk($sformatf("in_rdy%0d", c), int'(in_rdy[c]), int'(er));
      end
      if (rst_n && !fl) begin
         if (out_vld && ordy) begin
            log_d.push_back(out_data);
            log_c.push_back(int'(out_ch));
         end
         for (int c = 0; c < N; c++) if (v[c] && in_rdy[c]) acc_cnt++;
      end
      @(posedge clk);
      model_edge(v, d0, d1, ordy, fl);
      #1;
      check_outputs();
   endtask

   initial begin
      logic [W-1:0] hd;
      int           hc, exp_words;
      logic [1:0]   rv;
      logic [W-1:0] r0, r1;

      // Reset with inputs active
      rst_n = 1'b0; flush = 1'b0; in_vld = 2'b11; in_data = '1; out_rdy = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_rdy", int'(in_rdy), 0);
      chk("rst_out_vld", int'(out_vld), 0);
      chk("rst_occ", int'(occ), 0);
      chk("rst_out_data", int'(out_data), 0);
      chk("rst_out_ch", int'(out_ch), 0);
      rst_n = 1'b1;
      #1;
      chk("rdy_before_edge", int'(in_rdy), 0);
      step(2'b11, 9'h1FF, 9'h1FF, 1'b0, 1'b0);
      chk("rdy_after_release", int'(in_rdy), 3);
      chk("no_write_before_en", int'(occ), 0);

      // Table: single-word latency, then simultaneous push on both channels
      tbl[0] = '{2'b01, 9'h1A5, 9'h000, 1'b1, 2'b11, 1'b0, 9'h000, 0, 1, 0};
      tbl[1] = '{2'b00, 9'h000, 9'h000, 1'b1, 2'b11, 1'b1, 9'h1A5, 0, 0, 0};
      tbl[2] = '{2'b00, 9'h000, 9'h000, 1'b1, 2'b11, 1'b0, 9'h000, 0, 0, 0};
      tbl[3] = '{2'b11, 9'h011, 9'h111, 1'b1, 2'b11, 1'b0, 9'h000, 0, 1, 1};
      tbl[4] = '{2'b00, 9'h000, 9'h000, 1'b1, 2'b11, 1'b1, 9'h111, 1, 1, 0};
      tbl[5] = '{2'b00, 9'h000, 9'h000, 1'b1, 2'b11, 1'b1, 9'h011, 0, 0, 0};
      tbl[6] = '{2'b00, 9'h000, 9'h000, 1'b1, 2'b11, 1'b0, 9'h000, 0, 0, 0};
      for (int i = 0; i < 7; i++) begin
         step(tbl[i].v, tbl[i].d0, tbl[i].d1, tbl[i].ordy, 1'b0);
         chk($sformatf("tbl%0d_rdy", i), int'(pre_rdy), int'(tbl[i].exp_rdy));
         chk($sformatf("tbl%0d_vld", i), int'(out_vld), int'(tbl[i].exp_ovld));
         if (tbl[i].exp_ovld) begin
            chk($sformatf("tbl%0d_data", i), int'(out_data), int'(tbl[i].exp_data));
            chk($sformatf("tbl%0d_ch", i), int'(out_ch), tbl[i].exp_ch);
         end
         chk($sformatf("tbl%0d_occ0", i), int'(occ[0 +: CW]), tbl[i].exp_occ0);
         chk($sformatf("tbl%0d_occ1", i), int'(occ[CW +: CW]), tbl[i].exp_occ1);
      end

      // Fill ch1 under backpressure: 4 in the FIFO plus 1 in the output stage
      step(2'b00, 0, 0, 1'b0, 1'b1);
      for (int k = 0; k < 5; k++) step(2'b10, 0, W'(9'h0A0 + k), 1'b0, 1'b0);
      chk("fill_occ1", int'(occ[CW +: CW]), 4);
      chk("fill_rdy1", int'(in_rdy[1]), 0);
      chk("fill_held", int'(out_data), 9'h0A0);
      log_d.delete(); log_c.delete();
      repeat (7) step(2'b00, 0, 0, 1'b1, 1'b0);
      chk("fill_count", log_d.size(), 5);
      for (int k = 0; k < 5 && k < log_d.size(); k++) begin
         chk($sformatf("fill_word%0d", k), int'(log_d[k]), 9'h0A0 + k);
         chk($sformatf("fill_ch%0d", k), log_c[k], 1);
      end

      // Round-robin alternation from rr=0
      step(2'b00, 0, 0, 1'b0, 1'b1);
      for (int k = 0; k < 3; k++) step(2'b11, W'(9'h040 + k), W'(9'h0C0 + k), 1'b0, 1'b0);
      log_d.delete(); log_c.delete();
      repeat (8) step(2'b00, 0, 0, 1'b1, 1'b0);
      chk("rr_count", log_c.size(), 6);
      for (int k = 0; k < 6 && k < log_c.size(); k++) begin
         chk($sformatf("rr_ch%0d", k), log_c[k], k % 2);
         chk($sformatf("rr_data%0d", k), int'(log_d[k]),
             (k % 2 == 0) ? 9'h040 + k / 2 : 9'h0C0 + k / 2);
      end

      // Stall with continued pushes: output stable, nothing lost or duplicated
      step(2'b00, 0, 0, 1'b0, 1'b1);
      acc_cnt = 0;
      step(2'b01, 9'h033, 0, 1'b0, 1'b0);
      step(2'b00, 0, 0, 1'b0, 1'b0);
      hd = out_data;
      hc = int'(out_ch);
      chk("stall_loaded", int'(out_vld), 1);
      for (int k = 0; k < 5; k++) begin
         step(2'b11, W'($urandom), W'($urandom), 1'b0, 1'b0);
         chk("stall_data", int'(out_data), int'(hd));
         chk("stall_ch", int'(out_ch), hc);
      end
      exp_words = acc_cnt;
      log_d.delete(); log_c.delete();
      repeat (12) step(2'b00, 0, 0, 1'b1, 1'b0);
      chk("stall_words", log_d.size(), exp_words);
      if (log_d.size() > 0) chk("stall_first", int'(log_d[0]), 9'h033);

      // Flush with occ={3,2} and a word in the output stage
      step(2'b00, 0, 0, 1'b0, 1'b1);
      for (int k = 0; k < 3; k++) step(2'b11, W'(9'h010 + k), W'(9'h020 + k), 1'b0, 1'b0);
      chk("pre_flush_occ0", int'(occ[0 +: CW]), 2);
      chk("pre_flush_occ1", int'(occ[CW +: CW]), 3);
      chk("pre_flush_vld", int'(out_vld), 1);
      step(2'b11, 9'h1EE, 9'h1EE, 1'b1, 1'b1);
      chk("flush_occ", int'(occ), 0);
      chk("flush_vld", int'(out_vld), 0);
      step(2'b10, 0, 9'h155, 1'b1, 1'b0);
      step(2'b00, 0, 0, 1'b1, 1'b0);
      chk("post_flush_vld", int'(out_vld), 1);
      chk("post_flush_data", int'(out_data), 9'h155);
      chk("post_flush_ch", int'(out_ch), 1);

      // Random traffic with occasional flush and one asynchronous reset
      for (int i = 0; i < 400; i++) begin
         if (i == 200) begin
            rst_n = 1'b0;
            #1;
            chk("midrst_vld", int'(out_vld), 0);
            chk("midrst_occ", int'(occ), 0);
            chk("midrst_rdy", int'(in_rdy), 0);
            chk("midrst_data", int'(out_data), 0);
            model_reset();
            step(2'b11, 9'h0AA, 9'h055, 1'b1, 1'b0);
            step(2'b11, 9'h0AA, 9'h055, 1'b1, 1'b0);
            rst_n = 1'b1;
         end
         rv = 2'($urandom);
         r0 = W'($urandom);
         r1 = W'($urandom);
         step(rv, r0, r1, ($urandom_range(0, 3) != 0), ($urandom_range(0, 39) == 0));
      end

      $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
      $finish;
   end

endmodule
